// File: rtl/seg7_pkg.sv
// Shared types and the active-high abcdefg segment table for the 7-segment scan controller.
package seg7_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  // Index = hex nibble, bit 6 = segment a.
  localparam logic [6:0] SEG_PATTERN [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high abcdefg segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_PATTERN[i_nib];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: blank gap per digit slot, frame-aligned value
// commit over a valid/ready load port, optional leading-zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_load_valid,
  output logic                    o_load_ready,
  input  logic [4*NUM_DIGITS-1:0] i_load_data,
  input  logic [NUM_DIGITS-1:0]   i_load_dp,
  input  logic                    i_lz_blank,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame_done
);

  localparam int   CW  = $clog2(CLK_DIV);
  localparam int   DW  = $clog2(NUM_DIGITS);
  localparam logic POL = (ACTIVE_LOW != 0);

  state_t                  r_state, w_state_nxt;
  logic [DW-1:0]           r_digit, w_digit_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic                    w_frame_end;
  logic [4*NUM_DIGITS-1:0] r_act, r_pend, w_act_nxt;
  logic [NUM_DIGITS-1:0]   r_act_dp, r_pend_dp, w_act_dp_nxt;
  logic                    r_pend_valid, w_commit;
  logic [NUM_DIGITS-1:0]   r_an, w_an_hi, w_lz_vec;
  logic [6:0]              r_seg, w_seg_hi, w_dec;
  logic                    r_dp, w_dp_hi, r_frame_done;
  logic [3:0]              w_nib;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= OFF;
      r_digit <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_digit <= w_digit_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_digit_nxt = r_digit;
    w_cnt_nxt   = r_cnt;
    w_frame_end = 1'b0;
    if (!i_en) begin
      w_state_nxt = OFF;
      w_digit_nxt = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        OFF: begin
          w_state_nxt = BLANK;
          w_digit_nxt = '0;
          w_cnt_nxt   = '0;
        end
        BLANK: begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == CW'(BLANK_CYCLES - 1)) w_state_nxt = SHOW;
        end
        SHOW: begin
          if (r_cnt == CW'(CLK_DIV - 1)) begin
            w_state_nxt = BLANK;
            w_cnt_nxt   = '0;
            if (r_digit == DW'(NUM_DIGITS - 1)) begin
              w_digit_nxt = '0;
              w_frame_end = 1'b1;
            end else begin
              w_digit_nxt = r_digit + DW'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: w_state_nxt = OFF;
      endcase
    end
  end

  // Pending value lands at the frame wrap, or immediately while the display is off.
  assign w_commit     = r_pend_valid && (w_frame_end || (r_state == OFF));
  assign w_act_nxt    = w_commit ? r_pend    : r_act;
  assign w_act_dp_nxt = w_commit ? r_pend_dp : r_act_dp;
  assign o_load_ready = ~r_pend_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend       <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      r_act        <= '0;
      r_act_dp     <= '0;
    end else begin
      if (i_load_valid && o_load_ready) begin
        r_pend       <= i_load_data;
        r_pend_dp    <= i_load_dp;
        r_pend_valid <= 1'b1;
      end else if (w_commit) begin
        r_pend_valid <= 1'b0;
      end
      r_act    <= w_act_nxt;
      r_act_dp <= w_act_dp_nxt;
    end
  end

  assign w_nib = w_act_nxt[{w_digit_nxt, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .i_nib (w_nib),
    .o_seg (w_dec)
  );

  // Outputs are built from next-state values so they change on the same edge as the state.
  always_comb begin
    logic w_zero_run;
    w_zero_run = 1'b1;
    w_lz_vec   = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_run  = w_zero_run & (w_act_nxt[4*k +: 4] == 4'h0);
      w_lz_vec[k] = w_zero_run & (k != 0);
    end
    w_an_hi  = '0;
    w_seg_hi = '0;
    w_dp_hi  = 1'b0;
    if (w_state_nxt == SHOW) begin
      w_dp_hi = w_act_dp_nxt[w_digit_nxt];
      if (!(i_lz_blank && w_lz_vec[w_digit_nxt])) begin
        w_an_hi[w_digit_nxt] = 1'b1;
        w_seg_hi             = w_dec;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_an         <= {NUM_DIGITS{POL}};
      r_seg        <= {7{POL}};
      r_dp         <= POL;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_an_hi ^ {NUM_DIGITS{POL}};
      r_seg        <= w_seg_hi ^ {7{POL}};
      r_dp         <= w_dp_hi ^ POL;
      r_frame_done <= w_frame_end;
    end
  end

  assign o_an         = r_an;
  assign o_seg        = r_seg;
  assign o_dp         = r_dp;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with a short 8-cycle slot (2 blank + 6 show).
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, load_valid, lz_blank;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic        o_load_ready, o_dp, o_frame_done;
  logic [3:0]  o_an;
  logic [6:0]  o_seg;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (4),
    .CLK_DIV      (8),
    .BLANK_CYCLES (2),
    .ACTIVE_LOW   (1)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_load_valid (load_valid),
    .o_load_ready (o_load_ready),
    .i_load_data  (load_data),
    .i_load_dp    (load_dp),
    .i_lz_blank   (lz_blank),
    .o_an         (o_an),
    .o_seg        (o_seg),
    .o_dp         (o_dp),
    .o_frame_done (o_frame_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] an, input logic [6:0] seg,
                     input logic dp, input logic rdy, input logic fd);
    checks++;
    assert ({o_an, o_seg, o_dp, o_load_ready, o_frame_done} === {an, seg, dp, rdy, fd})
    else begin
      errors++;
      $error("FAIL %s: got an=%h seg=%h dp=%b rdy=%b fd=%b, expected an=%h seg=%h dp=%b rdy=%b fd=%b",
             tag, o_an, o_seg, o_dp, o_load_ready, o_frame_done, an, seg, dp, rdy, fd);
    end
  endtask

  // Starts on the first blank cycle of a slot, ends on the first blank cycle of the next.
  task automatic slot(input string tag, input logic [3:0] an, input logic [6:0] seg,
                      input logic dp, input logic fd0, input logic rdy0, input logic rdy,
                      input logic ld, input logic [15:0] ld_data, input logic [3:0] ld_dp);
    for (int i = 0; i < 8; i++) begin
      if (i < 2) chk(tag, 4'hF, 7'h7F, 1'b1, (i == 0) ? rdy0 : rdy, (i == 0) ? fd0 : 1'b0);
      else       chk(tag, an, seg, dp, rdy, 1'b0);
      if (i == 0 && ld) begin
        load_valid = 1'b1;
        load_data  = ld_data;
        load_dp    = ld_dp;
      end
      if (i == 1) load_valid = 1'b0;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load_valid = 1'b0; lz_blank = 1'b0;
    load_data = '0; load_dp = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset", 4'hF, 7'h7F, 1'b1, 1'b1, 1'b0);
    end
    rst = 1'b0;

    // Load while off, then start scanning.
    load_valid = 1'b1; load_data = 16'h12AF; load_dp = 4'b0100;
    tick();
    chk("off_load", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0);
    load_valid = 1'b0; en = 1'b1;
    tick();

    slot("f1d0", 4'hE, 7'h38, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
    slot("f1d1", 4'hD, 7'h08, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
    slot("f1d2", 4'hB, 7'h12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
    slot("f1d3", 4'h7, 7'h4F, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0);

    // Mid-frame load of 0000 must not disturb this frame.
    slot("f2d0", 4'hE, 7'h38, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
    slot("f2d1", 4'hD, 7'h08, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 4'h0);
    slot("f2d2", 4'hB, 7'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
    slot("f2d3", 4'h7, 7'h4F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0);

    // 0000 with leading-zero blanking; queue 0070 with dp on digit 3.
    lz_blank = 1'b1;
    slot("f3d0", 4'hE, 7'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0070, 4'b1000);
    slot("f3d1", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
    slot("f3d2", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
    slot("f3d3", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0);

    slot("f4d0", 4'hE, 7'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
    slot("f4d1", 4'hD, 7'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
    slot("f4d2", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
    slot("f4d3", 4'hF, 7'h7F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0);

    // Drop enable during the digit 2 show window.
    lz_blank = 1'b0;
    slot("f5d0", 4'hE, 7'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
    slot("f5d1", 4'hD, 7'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
    chk("f5d2_blank", 4'hF, 7'h7F, 1'b1, 1'b1, 1'b0);
    tick(); tick();
    chk("f5d2_show", 4'hB, 7'h01, 1'b1, 1'b1, 1'b0);
    en = 1'b0;
    tick();
    chk("en_off", 4'hF, 7'h7F, 1'b1, 1'b1, 1'b0);
    load_valid = 1'b1; load_data = 16'h3456; load_dp = 4'b0001;
    tick();
    chk("off_xfer", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0);
    load_valid = 1'b0;
    tick();
    chk("off_commit", 4'hF, 7'h7F, 1'b1, 1'b1, 1'b0);
    tick(); tick();
    chk("off_hold", 4'hF, 7'h7F, 1'b1, 1'b1, 1'b0);
    en = 1'b1;
    tick();

    slot("f6d0", 4'hE, 7'h20, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
    slot("f6d1", 4'hD, 7'h24, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
    slot("f6d2", 4'hB, 7'h4C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
    slot("f6d3", 4'h7, 7'h06, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0);

    // Reset mid-slot with ABCD pending: pending is lost, active clears to 0000.
    slot("f7d0", 4'hE, 7'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'hABCD, 4'h0);
    chk("f7d1_blank", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk("f7d1_show", 4'hD, 7'h24, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk("rst_mid", 4'hF, 7'h7F, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    tick();

    slot("f8d0", 4'hE, 7'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
    slot("f8d1", 4'hD, 7'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
    slot("f8d2", 4'hB, 7'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
    slot("f8d3", 4'h7, 7'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
    slot("f9d0", 4'hE, 7'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
